// File: rtl/store_buffer_pkg.sv
// -----------------------------------------------------------------------------
// store_buffer_pkg
// Shared defaults for the store buffer: datapath/address width, entry count,
// and the (addr, data) entry record used by the buffer and its forwarding
// selector.
// -----------------------------------------------------------------------------
package store_buffer_pkg;

    localparam int SB_WIDTH = 16;
    localparam int SB_DEPTH = 4;

    typedef struct packed {
        logic [SB_WIDTH-1:0] addr;
        logic [SB_WIDTH-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_fwd.sv
// -----------------------------------------------------------------------------
// store_buffer_fwd
// Combinational youngest-match selector for store-to-load forwarding.
// Ports:
//   i_entries  entry array (addr, data), indexed by slot
//   i_valid    per-slot pending flag
//   i_tail     next slot to be written (slot just before it is youngest)
//   i_ld_addr  load word address
//   o_hit      some pending entry matches i_ld_addr over all bits
//   o_data     data of the youngest matching entry (0 when no hit)
// -----------------------------------------------------------------------------
module store_buffer_fwd
    import store_buffer_pkg::*;
#(
    parameter int  n       = SB_WIDTH,
    parameter int  DEPTH   = SB_DEPTH,
    parameter type entry_t = sb_entry_t,
    localparam int PW      = $clog2(DEPTH)
) (
    input  entry_t           i_entries [DEPTH],
    input  logic [DEPTH-1:0] i_valid,
    input  logic [PW-1:0]    i_tail,
    input  logic [n-1:0]     i_ld_addr,
    output logic             o_hit,
    output logic [n-1:0]     o_data
);

    logic [PW-1:0] w_idx;

    // Walk slots from tail (oldest position) around to tail-1 (youngest);
    // later matches overwrite earlier ones, so the youngest match wins.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        w_idx  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_idx = i_tail + PW'(i);
            if (i_valid[w_idx] && (i_entries[w_idx].addr == i_ld_addr)) begin
                o_hit  = 1'b1;
                o_data = i_entries[w_idx].data;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
// FIFO of pending stores between the datapath and a single-port dmem.
// Stores drain to dmem whenever no load owns the port; loads are forwarded
// from the youngest matching pending store, otherwise served from dmem.
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   st_valid/addr/data      store request; st_ready = room in the buffer
//   ld_valid/addr           load request; ld_hit/ld_data = load result
//   mem_write_enable/addr/writedata, mem_readdata   dmem port
//   empty, count            occupancy status
// -----------------------------------------------------------------------------
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int n     = SB_WIDTH,
    parameter int DEPTH = SB_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   st_valid,
    input  logic [n-1:0]           st_addr,
    input  logic [n-1:0]           st_data,
    output logic                   st_ready,
    input  logic                   ld_valid,
    input  logic [n-1:0]           ld_addr,
    output logic                   ld_hit,
    output logic [n-1:0]           ld_data,
    output logic                   mem_write_enable,
    output logic [n-1:0]           mem_addr,
    output logic [n-1:0]           mem_writedata,
    input  logic [n-1:0]           mem_readdata,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [n-1:0] addr;
        logic [n-1:0] data;
    } entry_t;

    entry_t           r_entries [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [CW-1:0]    r_count;

    logic             w_enq;
    logic             w_drain;
    logic             w_fwd_hit;
    logic [n-1:0]     w_fwd_data;
    entry_t           w_head;

    // Ready depends only on the registered count, never on inputs.
    assign st_ready = (r_count < CW'(DEPTH));
    assign w_enq    = st_valid && st_ready;
    // A load owns the dmem port; draining only happens on load-free cycles.
    assign w_drain  = (r_count != '0) && !ld_valid;
    assign w_head   = r_entries[r_head];

    assign mem_write_enable = w_drain;
    assign mem_addr         = w_drain ? w_head.addr : ld_addr;
    assign mem_writedata    = w_head.data;

    assign empty = (r_count == '0);
    assign count = r_count;

    // The store arriving this cycle is not yet in the array, so a same-cycle
    // store to the load address is not forwarded.
    store_buffer_fwd #(
        .n       (n),
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fwd (
        .i_entries (r_entries),
        .i_valid   (r_valid),
        .i_tail    (r_tail),
        .i_ld_addr (ld_addr),
        .o_hit     (w_fwd_hit),
        .o_data    (w_fwd_data)
    );

    assign ld_hit  = ld_valid && w_fwd_hit;
    assign ld_data = ld_hit ? w_fwd_data : mem_readdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            // Enqueue and drain never touch the same slot: that would need
            // head==tail, i.e. empty (no drain) or full (no enqueue).
            if (w_drain) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
            end
            if (w_enq) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + 1'b1;
            end
            case ({w_enq, w_drain})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry payload is qualified by r_valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_entries[r_tail] <= '{addr: st_addr, data: st_data};
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// -----------------------------------------------------------------------------
// tb_store_buffer
// Self-checking bench for store_buffer with a behavioural dmem. A queue-based
// reference model predicts every cycle's outputs; a directed vector table,
// hand-written backpressure/reset sequences and random traffic drive the DUT.
// -----------------------------------------------------------------------------
module tb_store_buffer;
    import store_buffer_pkg::*;

    localparam int N  = SB_WIDTH;
    localparam int D  = SB_DEPTH;
    localparam int CW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          st_valid;
    logic [N-1:0]  st_addr;
    logic [N-1:0]  st_data;
    logic          st_ready;
    logic          ld_valid;
    logic [N-1:0]  ld_addr;
    logic          ld_hit;
    logic [N-1:0]  ld_data;
    logic          mem_write_enable;
    logic [N-1:0]  mem_addr;
    logic [N-1:0]  mem_writedata;
    logic [N-1:0]  mem_readdata;
    logic          empty;
    logic [CW-1:0] count;

    // dmem: combinational read, written at the clock edge by the step task
    logic [N-1:0] ram [512];
    assign mem_readdata = ram[mem_addr[8:0]];

    store_buffer #(.n(N), .DEPTH(D)) dut (
        .clk              (clk),
        .reset            (reset),
        .st_valid         (st_valid),
        .st_addr          (st_addr),
        .st_data          (st_data),
        .st_ready         (st_ready),
        .ld_valid         (ld_valid),
        .ld_addr          (ld_addr),
        .ld_hit           (ld_hit),
        .ld_data          (ld_data),
        .mem_write_enable (mem_write_enable),
        .mem_addr         (mem_addr),
        .mem_writedata    (mem_writedata),
        .mem_readdata     (mem_readdata),
        .empty            (empty),
        .count            (count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: pending stores in program order plus a model memory
    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] d;
    } ent_t;
    ent_t         mq [$];
    logic [N-1:0] mram [512];

    // Values sampled in the most recent step
    logic          s_ready, s_we, s_hit, s_empty;
    logic [N-1:0]  s_addr, s_wdata, s_ld;
    logic [CW-1:0] s_count;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare against the model, advance.
    task automatic step(input logic sv, input logic [N-1:0] sa, input logic [N-1:0] sd,
                        input logic lv, input logic [N-1:0] la);
        int unsigned  sz;
        logic         e_we, e_hit;
        logic [N-1:0] e_addr, e_ld;
        ent_t         e;
        @(negedge clk);
        st_valid = sv; st_addr = sa; st_data = sd;
        ld_valid = lv; ld_addr = la;
        #1;
        s_ready = st_ready; s_we = mem_write_enable; s_addr = mem_addr;
        s_wdata = mem_writedata; s_hit = ld_hit; s_ld = ld_data;
        s_empty = empty; s_count = count;

        sz     = mq.size();
        e_we   = (sz != 0) && !lv;
        e_addr = e_we ? mq[0].a : la;
        e_hit  = 1'b0;
        e_ld   = '0;
        if (lv) begin
            foreach (mq[i]) begin
                if (mq[i].a == la) begin
                    e_hit = 1'b1;
                    e_ld  = mq[i].d;
                end
            end
        end
        if (!e_hit) e_ld = mram[e_addr[8:0]];

        chk("st_ready", 32'(s_ready), 32'(sz < D));
        chk("count",    32'(s_count), sz);
        chk("empty",    32'(s_empty), 32'(sz == 0));
        chk("mem_we",   32'(s_we),    32'(e_we));
        chk("mem_addr", 32'(s_addr),  32'(e_addr));
        if (e_we) chk("mem_wdata", 32'(s_wdata), 32'(mq[0].d));
        chk("ld_hit",   32'(s_hit),   32'(e_hit));
        chk("ld_data",  32'(s_ld),    32'(e_ld));

        if (e_we) begin
            mram[mq[0].a[8:0]] = mq[0].d;
            void'(mq.pop_front());
        end
        if (sv && (sz < D)) begin
            e.a = sa;
            e.d = sd;
            mq.push_back(e);
        end
        @(posedge clk);
        if (s_we) ram[s_addr[8:0]] = s_wdata;
        cyc++;
    endtask

    typedef struct {
        logic         sv;
        logic [N-1:0] sa;
        logic [N-1:0] sd;
        logic         lv;
        logic [N-1:0] la;
        logic         we;
        logic [N-1:0] addr;
        logic [N-1:0] wdata;
        logic         hit;
        logic [N-1:0] ld;
        int           cnt;
    } vec_t;
    vec_t tbl [13];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            sv  sa       sd       lv  la       we  addr     wdata    hit ld       cnt
        tbl[0]  = '{1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 0};
        tbl[1]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0000, 1};
        tbl[2]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 0};
        tbl[3]  = '{1'b1, 16'h0020, 16'h1111, 1'b1, 16'h0040, 1'b0, 16'h0040, 16'h0000, 1'b0, 16'h0000, 0};
        tbl[4]  = '{1'b1, 16'h0020, 16'h2222, 1'b1, 16'h0040, 1'b0, 16'h0040, 16'h0000, 1'b0, 16'h0000, 1};
        tbl[5]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0020, 1'b0, 16'h0020, 16'h0000, 1'b1, 16'h2222, 2};
        tbl[6]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0030, 1'b0, 16'h0030, 16'h0000, 1'b0, 16'h00AA, 2};
        tbl[7]  = '{1'b1, 16'h0030, 16'h5555, 1'b1, 16'h0030, 1'b0, 16'h0030, 16'h0000, 1'b0, 16'h00AA, 2};
        tbl[8]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0030, 1'b0, 16'h0030, 16'h0000, 1'b1, 16'h5555, 3};
        tbl[9]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0020, 16'h1111, 1'b0, 16'h0000, 3};
        tbl[10] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0020, 16'h2222, 1'b0, 16'h1111, 2};
        tbl[11] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0030, 16'h5555, 1'b0, 16'h00AA, 1};
        tbl[12] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 0};

        for (int i = 0; i < 512; i++) begin
            ram[i]  = '0;
            mram[i] = '0;
        end
        ram[9'h030]  = 16'h00AA;
        mram[9'h030] = 16'h00AA;

        // Reset state (a load is presented to show no hit is reported)
        reset = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0;
        ld_valid = 1'b1; ld_addr = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_empty",    32'(empty), 32'd1);
        chk("rst_count",    32'(count), 32'd0);
        chk("rst_st_ready", 32'(st_ready), 32'd1);
        chk("rst_mem_we",   32'(mem_write_enable), 32'd0);
        chk("rst_ld_hit",   32'(ld_hit), 32'd0);
        @(negedge clk);
        reset = 1'b0; ld_valid = 1'b0;

        // Directed vector table
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].sv, tbl[i].sa, tbl[i].sd, tbl[i].lv, tbl[i].la);
            chk("tbl_we",    32'(s_we),    32'(tbl[i].we));
            chk("tbl_addr",  32'(s_addr),  32'(tbl[i].addr));
            if (tbl[i].we) chk("tbl_wdata", 32'(s_wdata), 32'(tbl[i].wdata));
            chk("tbl_hit",   32'(s_hit),   32'(tbl[i].hit));
            chk("tbl_ld",    32'(s_ld),    32'(tbl[i].ld));
            chk("tbl_count", 32'(s_count), tbl[i].cnt);
        end
        chk("ram_10", 32'(ram[9'h010]), 32'h0000BEEF);
        chk("ram_20", 32'(ram[9'h020]), 32'h00002222);
        chk("ram_30", 32'(ram[9'h030]), 32'h00005555);

        // Backpressure: a held load blocks draining while 5 stores are offered
        for (int i = 0; i < 6; i++) begin
            int k;
            k = (i < 4) ? i : 4;
            step(1'b1, N'(16'h0100 + k), N'(16'hA000 + k), 1'b1, 16'h0000);
            chk("bp_no_write", 32'(s_we), 32'd0);
            if (i == 4) begin
                chk("bp_ready_low", 32'(s_ready), 32'd0);
                chk("bp_count4",    32'(s_count), 32'd4);
            end
        end
        // Full with a store offered and a drain allowed in the same cycle
        step(1'b1, 16'h0104, 16'hA004, 1'b0, 16'h0000);
        chk("full_ready",   32'(s_ready), 32'd0);
        chk("full_we",      32'(s_we),    32'd1);
        chk("full_addr",    32'(s_addr),  32'h0100);
        step(1'b1, 16'h0104, 16'hA004, 1'b0, 16'h0000);
        chk("after_count",  32'(s_count), 32'd3);
        chk("after_ready",  32'(s_ready), 32'd1);
        chk("after_addr",   32'(s_addr),  32'h0101);
        for (int i = 2; i < 5; i++) begin
            step(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
            chk("drain_addr", 32'(s_addr), 32'(16'h0100 + i));
        end
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
        chk("drain_done", 32'(s_empty), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_ram", 32'(ram[9'h100 + i]), 32'(16'hA000 + i));
        end

        // Reset with 3 stores pending discards them
        step(1'b1, 16'h0040, 16'hC001, 1'b1, 16'h0050);
        step(1'b1, 16'h0041, 16'hC002, 1'b1, 16'h0050);
        step(1'b1, 16'h0042, 16'hC003, 1'b1, 16'h0050);
        @(negedge clk);
        st_valid = 1'b0; ld_valid = 1'b1; ld_addr = 16'h0040;
        #1;
        chk("pre_rst_hit", 32'(ld_hit), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_we",    32'(mem_write_enable), 32'd0);
        chk("mid_rst_hit",   32'(ld_hit), 32'd0);
        mq.delete();
        @(negedge clk);
        reset = 1'b0; ld_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0040);
            chk("post_rst_no_write", 32'(s_we), 32'd0);
        end
        chk("post_rst_ram", 32'(ram[9'h040]), 32'd0);

        // Random traffic over a small address window to provoke hits
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), N'($urandom_range(0, 7)), N'($urandom),
                 1'($urandom_range(0, 9) < 3), N'($urandom_range(0, 7)));
        end
        repeat (D + 2) step(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
        for (int i = 0; i < 8; i++) begin
            chk("rand_ram", 32'(ram[i]), 32'(mram[i]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
